// File: rtl/axis_writer_pkg.sv
// Shared types and constants for the AXI-Stream to AXI4 burst writer.
// Optional bresp checking in the top is enabled by AXIS_WRITER_BRESP_CHECK_EN.
package axis_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_DONE
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   function automatic logic [2:0] calc_awsize(input int data_w);
      case (data_w)
         8:       return 3'd0;
         16:      return 3'd1;
         32:      return 3'd2;
         64:      return 3'd3;
         128:     return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/axi_burst_planner.sv
// Tracks the write address and the beats still to be issued, and sizes each burst.
// Advances by one whole burst on the burst-complete strobe.
module axi_burst_planner
   import axis_writer_pkg::*;
#(
   parameter int BURST_LEN = 16,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       total_beats,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        awlen,
   output logic              last_burst,
   output logic              empty
);

   localparam logic [15:0] MAX_LEN    = 16'(BURST_LEN);
   localparam int          SIZE_SHIFT = int'(calc_awsize(DATA_W));

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       rem_q, rem_d;
   logic [15:0]       len;

   assign last_burst = (rem_q <= MAX_LEN);
   assign empty      = (rem_q == 16'd0);
   assign len        = last_burst ? rem_q : MAX_LEN;
   // Hold awlen at zero when nothing is left so it never shows the wrapped value.
   assign awlen      = empty ? 8'd0 : 8'(len - 16'd1);
   assign addr       = addr_q;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load) begin
         addr_d = base_addr;
         rem_d  = total_beats;
      end else if (advance) begin
         addr_d = addr_q + (ADDR_W'(len) << SIZE_SHIFT);
         rem_d  = rem_q - len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

endmodule

// File: rtl/axis_burst_writer.sv
// AXI4 write master draining an AXI-Stream into memory as one-at-a-time INCR bursts.
// Define AXIS_WRITER_BRESP_CHECK_EN to flag non-OKAY write responses and stop early.
module axis_burst_writer
   import axis_writer_pkg::*;
#(
   parameter int C_M_AXI_BURST_LEN  = 16,
   parameter int C_M_AXI_ID_WIDTH   = 8,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
)(
   input  logic                            m_axi_aclk,
   input  logic                            m_axi_aresetn,
   input  logic                            start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
   input  logic [15:0]                     total_beats,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                      m_axi_awlen,
   output logic [2:0]                      m_axi_awsize,
   output logic [1:0]                      m_axi_awburst,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wlast,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready
);

   state_t     state_q, state_d;
   logic       error_q, error_d;
   logic [7:0] beat_q, beat_d;
   logic       load, advance;
   logic       last_burst, empty;
   logic       in_data, w_hs, final_beat;
   logic       unused_ok;

   axi_burst_planner #(
      .BURST_LEN (C_M_AXI_BURST_LEN),
      .ADDR_W    (C_M_AXI_ADDR_WIDTH),
      .DATA_W    (C_M_AXI_DATA_WIDTH)
   ) u_planner (
      .clk         (m_axi_aclk),
      .rst_n       (m_axi_aresetn),
      .load        (load),
      .advance     (advance),
      .base_addr   (base_addr),
      .total_beats (total_beats),
      .addr        (m_axi_awaddr),
      .awlen       (m_axi_awlen),
      .last_burst  (last_burst),
      .empty       (empty)
   );

   assign in_data    = (state_q == ST_DATA);
   assign w_hs       = in_data && s_axis_tvalid && m_axi_wready;
   // The very last beat of the whole transfer is the only one allowed to carry tlast.
   assign final_beat = last_burst && (beat_q == m_axi_awlen);

   assign m_axi_awid    = '0;
   assign m_axi_awsize  = calc_awsize(C_M_AXI_DATA_WIDTH);
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awvalid = (state_q == ST_ADDR);
   assign m_axi_wdata   = in_data ? s_axis_tdata : '0;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = in_data && s_axis_tvalid;
   assign m_axi_wlast   = in_data && (beat_q == m_axi_awlen);
   assign s_axis_tready = in_data && m_axi_wready;
   assign m_axi_bready  = (state_q == ST_RESP);
   assign busy          = (state_q == ST_ADDR) || in_data || (state_q == ST_RESP);
   assign done          = (state_q == ST_DONE);
   assign error         = error_q;
   assign unused_ok     = ^{m_axi_bid, m_axi_bresp};

   always_comb begin
      state_d = state_q;
      error_d = error_q;
      beat_d  = beat_q;
      load    = 1'b0;
      advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               load    = 1'b1;
               error_d = 1'b0;
               state_d = (total_beats == 16'd0) ? ST_DONE : ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (m_axi_awready) begin
               beat_d  = 8'd0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               if (s_axis_tlast != final_beat) error_d = 1'b1;
               if (beat_q == m_axi_awlen) begin
                  advance = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         ST_RESP: begin
            if (m_axi_bvalid) begin
`ifdef AXIS_WRITER_BRESP_CHECK_EN
               if (m_axi_bresp != RESP_OKAY) begin
                  error_d = 1'b1;
                  state_d = ST_DONE;
               end else
`endif
               state_d = empty ? ST_DONE : ST_ADDR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         state_q <= ST_IDLE;
         error_q <= 1'b0;
         beat_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_axis_burst_writer.sv
// Randomised self-checking bench for axis_burst_writer against a queue-based transfer model.
module tb_axis_burst_writer;

   localparam int BL  = 16;
   localparam int IDW = 8;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [15:0]     total_beats = '0;
   logic            busy, done, error;
   logic [IDW-1:0]  awid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid, awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast, wvalid, wready;
   logic [IDW-1:0]  bid;
   logic [1:0]      bresp;
   logic            bvalid, bready;
   logic [DW-1:0]   tdata;
   logic            tvalid, tlast, tready;

   always #5 clk = ~clk;

   axis_burst_writer #(
      .C_M_AXI_BURST_LEN (BL),
      .C_M_AXI_ID_WIDTH  (IDW),
      .C_M_AXI_ADDR_WIDTH(AW),
      .C_M_AXI_DATA_WIDTH(DW)
   ) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .start(start), .base_addr(base_addr), .total_beats(total_beats),
      .busy(busy), .done(done), .error(error),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   aw_t         exp_aw[$];
   logic [32:0] exp_w[$];      // {wlast, wdata}
   logic [32:0] src_q[$];      // {tlast, tdata}
   logic [1:0]  resp_tbl[0:15];

   int tests = 0;
   int fails = 0;
   int bursts_left = 0, b_pending = 0, b_idx = 0;
   int aw_hs_count = 0, w_bursts_done = 0, w_hs_count = 0;
   logic [31:0] first_aw_addr, last_aw_addr;
   logic [7:0]  first_aw_len, last_aw_len;
   bit exp_busy = 0, exp_done = 0;
   bit random_mode = 0;
   bit b_acc = 0, s_acc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awvalid"}, awvalid, 0);
      check({tag, "_wvalid"},  wvalid,  0);
      check({tag, "_wlast"},   wlast,   0);
      check({tag, "_bready"},  bready,  0);
      check({tag, "_tready"},  tready,  0);
      check({tag, "_busy"},    busy,    0);
      check({tag, "_done"},    done,    0);
      check({tag, "_error"},   error,   0);
      check({tag, "_awaddr"},  awaddr,  0);
      check({tag, "_awlen"},   awlen,   0);
      check({tag, "_awburst"}, awburst, 2'b01);
      check({tag, "_awsize"},  awsize,  3'd2);
      check({tag, "_wstrb"},   wstrb,   4'hf);
      check({tag, "_awid"},    awid,    0);
   endtask

   // Slave/source driver plus the single per-cycle compare process.
   initial begin
      bit nb, nd;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
      tvalid = 0; tdata = '0; tlast = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_aw.delete(); exp_w.delete(); src_q.delete();
            exp_busy = 0; exp_done = 0; b_pending = 0; bursts_left = 0;
            b_acc = 0; s_acc = 0;
         end else begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            nb = exp_busy;
            nd = 0;
            if (start && !busy && !done) begin
               if (total_beats == 16'd0) begin nb = 0; nd = 1; end
               else nb = 1;
            end
            if (busy) check("stream_hs", tvalid && tready, wvalid && wready);
            if (wvalid && (aw_hs_count <= w_bursts_done)) check("w_before_aw", 1, 0);
            s_acc = tvalid && tready;
            if (wvalid && wready) begin
               if (exp_w.size() == 0) check("w_unexpected", 1, 0);
               else begin
                  check("wdata", wdata, exp_w[0][31:0]);
                  check("wlast", wlast, exp_w[0][32]);
                  if (exp_w[0][32]) begin w_bursts_done++; b_pending++; end
                  void'(exp_w.pop_front());
               end
               w_hs_count++;
            end
            if (s_acc && src_q.size() > 0) void'(src_q.pop_front());
            if (awvalid) begin
               if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
               else begin
                  check("awaddr", awaddr, exp_aw[0].addr);
                  check("awlen", awlen, exp_aw[0].len);
                  if (awready) begin
                     if (aw_hs_count == 0) begin first_aw_addr = awaddr; first_aw_len = awlen; end
                     last_aw_addr = awaddr;
                     last_aw_len  = awlen;
                     void'(exp_aw.pop_front());
                     aw_hs_count++;
                  end
               end
            end
            b_acc = bvalid && bready;
            if (b_acc) begin
               b_pending--;
               b_idx++;
               bursts_left--;
               if (bursts_left == 0) begin nb = 0; nd = 1; end
            end
            exp_busy = nb;
            exp_done = nd;
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; tvalid = 0; tlast = 0; tdata = '0;
         end else begin
            awready = random_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            wready  = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bvalid && !b_acc) bvalid = 1'b1;
            else bvalid = (b_pending > 0) && (random_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
            bresp = (b_idx < 16) ? resp_tbl[b_idx] : 2'b00;
            if (tvalid && !s_acc && src_q.size() > 0) tvalid = 1'b1;
            else tvalid = (src_q.size() > 0) && (random_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (src_q.size() > 0) {tlast, tdata} = src_q[0];
            else begin tlast = 0; tdata = '0; end
         end
      end
   end

   task automatic run_xfer(input logic [31:0] base, input int total, input int tlast_pos,
                           input int slverr_burst, input bit stall);
      int nb_total, nb_exec, exec_beats, len, off;
      bit exp_err, timed_out;
      nb_total = (total + BL - 1) / BL;
      nb_exec  = nb_total;
      exp_err  = (total > 0) && (tlast_pos != total - 1);
`ifdef AXIS_WRITER_BRESP_CHECK_EN
      if (slverr_burst >= 0 && slverr_burst < nb_total) begin
         nb_exec = slverr_burst + 1;
         exp_err = 1;
      end
`endif
      for (int i = 0; i < 16; i++) resp_tbl[i] = (i == slverr_burst) ? 2'b10 : 2'b00;
      for (int i = 0; i < total; i++) src_q.push_back({(i == tlast_pos) ? 1'b1 : 1'b0, $urandom()});
      exec_beats = 0;
      for (int k = 0; k < nb_exec; k++) begin
         off = k * BL;
         len = (total - off < BL) ? (total - off) : BL;
         exp_aw.push_back('{addr: base + 32'(off * (DW / 8)), len: 8'(len - 1)});
         for (int j = 0; j < len; j++) exp_w.push_back({(j == len - 1) ? 1'b1 : 1'b0, src_q[off + j][31:0]});
         exec_beats += len;
      end
      random_mode   = stall;
      bursts_left   = nb_exec;
      b_pending     = 0;
      b_idx         = 0;
      aw_hs_count   = 0;
      w_bursts_done = 0;
      w_hs_count    = 0;
      @(posedge clk); #1;
      start = 1; base_addr = base; total_beats = 16'(total);
      @(posedge clk); #1;
      start = 0; base_addr = $urandom(); total_beats = 16'($urandom());
      @(negedge clk);
      check("error_cleared", error, 0);
      timed_out = 1;
      for (int c = 0; c < 4000; c++) begin
         if (done) begin timed_out = 0; break; end
         @(negedge clk);
      end
      if (timed_out) check("done_timeout", 0, 1);
      check("error", error, exp_err);
      check("aw_left", exp_aw.size(), 0);
      check("w_left", exp_w.size(), 0);
      check("w_beats", w_hs_count, exec_beats);
      check("aw_count", aw_hs_count, nb_exec);
      $display("[TB] xfer base=0x%08h total=%0d tlast_pos=%0d slverr=%0d stall=%0d aws=%0d beats=%0d err=%0d",
               base, total, tlast_pos, slverr_burst, stall, aw_hs_count, w_hs_count, error);
      src_q.delete();
      exp_w.delete();
      exp_aw.delete();
   endtask

   initial begin
      int tot, tp;
      bit timed_out;
      for (int i = 0; i < 16; i++) resp_tbl[i] = 2'b00;
      #12;
      check_reset_outputs("rst");
      @(posedge clk); #1;
      rst_n = 1;
      repeat (2) @(posedge clk);

      // Single burst, no stalls.
      run_xfer(32'h1000, 16, 15, -1, 0);
      check("single_first_aw_addr", first_aw_addr, 32'h1000);
      check("single_first_aw_len", first_aw_len, 8'd15);

      // Three bursts, no stalls.
      run_xfer(32'h1000, 40, 39, -1, 0);
      check("multi_last_aw_addr", last_aw_addr, 32'h1080);
      check("multi_last_aw_len", last_aw_len, 8'd7);
      check("multi_beats", w_hs_count, 40);

      // Same transfer under random backpressure on every channel.
      run_xfer(32'h1000, 40, 39, -1, 1);
      check("bp_beats", w_hs_count, 40);

      // Zero length completes with no AXI traffic.
      run_xfer(32'h2000, 0, -1, -1, 0);
      check("zero_aw_count", aw_hs_count, 0);

      // Early tlast flags an error but the transfer still runs to completion.
      run_xfer(32'h3000, 16, 4, -1, 0);
      check("framing_error", error, 1);
      check("framing_beats", w_hs_count, 16);

      // SLVERR on the first of three bursts.
      run_xfer(32'h4000, 40, 39, 0, 0);
`ifdef AXIS_WRITER_BRESP_CHECK_EN
      check("slverr_aw_count", aw_hs_count, 1);
`else
      check("slverr_aw_count", aw_hs_count, 3);
`endif

      // Randomised transfers.
      for (int n = 0; n < 6; n++) begin
         tot = $urandom_range(0, 70);
         if (tot == 0) tp = -1;
         else if ($urandom_range(0, 3) == 0) tp = $urandom_range(0, tot - 1);
         else tp = tot - 1;
         run_xfer(32'($urandom_range(0, 255) * 64), tot, tp, -1, 1);
      end

      // Reset in the middle of the data phase.
      for (int i = 0; i < 40; i++) src_q.push_back({(i == 39) ? 1'b1 : 1'b0, $urandom()});
      for (int k = 0; k < 3; k++) exp_aw.push_back('{addr: 32'h5000 + 32'(k * 64), len: (k == 2) ? 8'd7 : 8'd15});
      for (int i = 0; i < 40; i++) exp_w.push_back({(i % 16 == 15 || i == 39) ? 1'b1 : 1'b0, src_q[i][31:0]});
      random_mode = 1; bursts_left = 3; b_pending = 0; b_idx = 0;
      aw_hs_count = 0; w_bursts_done = 0; w_hs_count = 0;
      @(posedge clk); #1;
      start = 1; base_addr = 32'h5000; total_beats = 16'd40;
      @(posedge clk); #1;
      start = 0;
      timed_out = 1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (w_hs_count >= 3 && wvalid) begin timed_out = 0; break; end
      end
      if (timed_out) check("mid_reset_wait", 0, 1);
      #2;
      rst_n = 0;
      #1;
      check_reset_outputs("midrst");
      $display("[TB] reset asserted mid-transfer after %0d beats", w_hs_count);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      run_xfer(32'h6000, 20, 19, -1, 1);
      check("post_reset_first_aw_addr", first_aw_addr, 32'h6000);
      check("post_reset_last_aw_len", last_aw_len, 8'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
